// File: rtl/fir_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed FIR family.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Accumulator width: full product plus guard bits so an N-tap sum never wraps.
  function automatic int acc_width(input int coef_w, input int data_w, input int n_taps);
    return coef_w + data_w + $clog2(n_taps);
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    if (v > sat_max(w)) begin
      return sat_max(w);
    end else if (v < sat_min(w)) begin
      return sat_min(w);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational shift, optional round-half-up and clip of a wide accumulator.
// Define FIR_TDM_ROUND_EN to add half an LSB before the shift; otherwise truncate toward -inf.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W  = 35,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     sat_o
);

`ifdef FIR_TDM_ROUND_EN
  localparam logic signed [ACC_W:0] RND_C = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W - 1);
`endif

  logic signed [ACC_W:0] biased_s;
  logic signed [ACC_W:0] shifted_s;
  logic signed [63:0]    wide_s;
  logic signed [63:0]    clip_s;

  // Extra headroom bit keeps the rounding add from wrapping.
  always_comb begin
`ifdef FIR_TDM_ROUND_EN
    biased_s = $signed({acc_i[ACC_W-1], acc_i}) + RND_C;
`else
    biased_s = $signed({acc_i[ACC_W-1], acc_i});
`endif
    shifted_s = biased_s >>> FRAC_W;
    wide_s    = 64'(shifted_s);
    clip_s    = sat_to_width(wide_s, DATA_W);
    data_o    = DATA_W'(clip_s);
    sat_o     = (clip_s != wide_s);
  end

endmodule

// File: rtl/fir_tdm.sv
// N-tap direct-form FIR sharing one multiplier/accumulator across all taps of a sample.
// Rounding is selected at build time with FIR_TDM_ROUND_EN (see fir_round_sat).
module fir_tdm
  import fir_pkg::*;
#(
  parameter int N_TAPS = 8,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 15
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [DATA_W-1:0]  data_i,
  output logic                      valid_o,
  output logic signed [DATA_W-1:0]  data_o,
  output logic                      sat_o,
  input  logic                      coef_we_i,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr_i,
  input  logic signed [COEF_W-1:0]  coef_data_i
);

  localparam int AW    = $clog2(N_TAPS);
  localparam int PW    = COEF_W + DATA_W;
  localparam int ACC_W = acc_width(COEF_W, DATA_W, N_TAPS);
  localparam logic signed [COEF_W-1:0] COEF_RST = {1'b0, {(COEF_W-1){1'b1}}};

  state_e                   state_q, state_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            rd_idx_s;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] delay_q [N_TAPS];
  logic signed [COEF_W-1:0] coef_q  [N_TAPS];
  logic signed [DATA_W-1:0] data_q, data_d, rs_data_s;
  logic                     valid_q, valid_d, sat_q, sat_d, rs_sat_s;
  logic signed [COEF_W-1:0] tap_coef_s;
  logic signed [DATA_W-1:0] tap_data_s;
  logic signed [PW-1:0]     prod_s;
  logic                     accept_s, coef_wr_s;

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sat_o   = sat_q;

  assign accept_s  = valid_i && (state_q == ST_IDLE);
  assign coef_wr_s = coef_we_i && (state_q == ST_IDLE) && (int'(coef_addr_i) < N_TAPS);

  // Tap k reads x[n-k]: walk the circular delay line backwards from the newest sample.
  always_comb begin
    if (wr_ptr_q >= cnt_q) begin
      rd_idx_s = wr_ptr_q - cnt_q;
    end else begin
      rd_idx_s = AW'(int'(wr_ptr_q) + N_TAPS - int'(cnt_q));
    end
    tap_coef_s = coef_q[cnt_q];
    tap_data_s = delay_q[rd_idx_s];
    prod_s     = PW'(tap_coef_s) * PW'(tap_data_s);
  end

  // The final sum is registered at the last MAC edge so valid_o coincides with the OUT cycle.
  fir_round_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .acc_i (acc_d),
    .data_o(rs_data_s),
    .sat_o (rs_sat_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    sat_d    = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MAC;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod_s);
        if (cnt_q == AW'(N_TAPS - 1)) begin
          state_d = ST_OUT;
          valid_d = 1'b1;
          data_d  = rs_data_s;
          sat_d   = rs_sat_s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
        if (wr_ptr_q == AW'(N_TAPS - 1)) begin
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, delay line, coefficient bank and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= (i == 0) ? COEF_RST : '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sat_q    <= sat_d;
      if (accept_s) begin
        delay_q[wr_ptr_q] <= data_i;
      end
      if (coef_wr_s) begin
        coef_q[coef_addr_i] <= coef_data_i;
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm.sv
// Scoreboard bench for fir_tdm: a convolution model predicts each output at accept time.
module tb_fir_tdm;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int FW = 15;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_i = '0;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          sat_o;
  logic          coef_we_i = 1'b0;
  logic [AW-1:0] coef_addr_i = '0;
  logic [CW-1:0] coef_data_i = '0;

  fir_tdm #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .FRAC_W(FW)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .data_o(data_o), .sat_o(sat_o),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   m_coef[N];
  int   hist[N];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   prev_acc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_coef[k] = (k == 0) ? 32'h7FFF : 0;
      hist[k]   = 0;
    end
    sb.delete();
  endfunction

  // y[n] = sum_k c[k]*x[n-k], scaled by 2^-FW, then clipped to the output range.
  function automatic void model_accept(input logic [DW-1:0] d);
    longint acc;
    exp_t   e;
    for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'($signed(d));
    acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(m_coef[k]) * longint'(hist[k]);
`ifdef FIR_TDM_ROUND_EN
    acc += longint'(1) << (FW - 1);
`endif
    acc = acc >>> FW;
    e.s = 1'b0;
    if (acc > 32767) begin
      acc = 32767;
      e.s = 1'b1;
    end else if (acc < -32768) begin
      acc = -32768;
      e.s = 1'b1;
    end
    e.d   = acc[DW-1:0];
    e.cyc = cyc + N + 1;
    sb.push_back(e);
  endfunction

  // Monitor: every valid_o pulse must match the oldest pending prediction, on time.
  exp_t got_e;
  always @(negedge clk) begin
    if (reset_ni && valid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: data_o=%h with no sample pending", data_o);
      end else begin
        got_e = sb.pop_front();
        check("out_data", 32'(data_o), 32'(got_e.d));
        check("out_sat", 32'(sat_o), 32'(got_e.s));
        check("out_latency", cyc, got_e.cyc);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit hold);
    valid_i = 1'b1;
    data_i  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready_o) begin
        model_accept(d);
        if (hold && prev_acc >= 0) check("accept_spacing", cyc - prev_acc, N + 2);
        prev_acc = cyc;
        @(posedge clk);
        #1;
        if (!hold) valid_i = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    valid_i = 1'b0;
  endtask

  task automatic coef_write(input int addr, input logic [CW-1:0] val, input bit taken);
    coef_we_i   = 1'b1;
    coef_addr_i = AW'(addr);
    coef_data_i = val;
    @(posedge clk);
    #1;
    coef_we_i = 1'b0;
    if (taken) m_coef[addr] = int'($signed(val));
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic random_coefs();
    for (int k = 0; k < N; k++) coef_write(k, 16'($urandom_range(0, 32'h3FFF)) - 16'h2000, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_data"}, 32'(data_o), 32'd0);
    check({tag, "_sat"}, 32'(sat_o), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 32'(ready_o), 32'd1);

    // Identity coefficient from reset.
    send(16'h1234, 1'b0);
    drain();
`ifdef FIR_TDM_ROUND_EN
    check("t1_data", 32'(data_o), 32'h1234);
`else
    check("t1_data", 32'(data_o), 32'h1233);
`endif
    check("t1_sat", 32'(sat_o), 32'd0);

    // Two half-weight taps.
    do_reset();
    coef_write(0, 16'h4000, 1'b1);
    coef_write(1, 16'h4000, 1'b1);
    send(16'h2000, 1'b0);
    drain();
    check("t2_first", 32'(data_o), 32'h1000);
    send(16'h2000, 1'b0);
    drain();
    check("t2_second", 32'(data_o), 32'h2000);
    check("t2_sat", 32'(sat_o), 32'd0);

    // Saturation at both rails.
    do_reset();
    for (int k = 0; k < N; k++) coef_write(k, 16'h7FFF, 1'b1);
    repeat (N) send(16'h7FFF, 1'b0);
    drain();
    check("t3_pos_data", 32'(data_o), 32'h7FFF);
    check("t3_pos_sat", 32'(sat_o), 32'd1);
    repeat (N) send(16'h8000, 1'b0);
    drain();
    check("t3_neg_data", 32'(data_o), 32'h8000);
    check("t3_neg_sat", 32'(sat_o), 32'd1);

    // valid_i held high; a coefficient write during MAC must be dropped.
    do_reset();
    random_coefs();
    prev_acc = -1;
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom()), 1'b1);
      if (i == 2) coef_write(0, 16'(m_coef[0]) ^ 16'h5555, 1'b0);
    end
    valid_i = 1'b0;
    drain();

    // Reset mid-MAC aborts the sample.
    send(16'($urandom()), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_ni = 1'b0;
    #1;
    check_reset_outputs("t5_abort");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    repeat (N + 4) @(posedge clk);
    #1;
    check("t5_quiet_data", 32'(data_o), 32'd0);
    send(16'h4000, 1'b0);
    drain();
`ifdef FIR_TDM_ROUND_EN
    check("t5_impulse", 32'(data_o), 32'h4000);
`else
    check("t5_impulse", 32'(data_o), 32'h3FFF);
`endif

    // Impulse response traces the coefficients through the delay-line wrap.
    do_reset();
    random_coefs();
    send(16'h7FFF, 1'b0);
    repeat (N + 2) send(16'h0000, 1'b0);
    drain();

    // Random data with random idle gaps.
    do_reset();
    random_coefs();
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(16'($urandom()), 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
